// File: rtl/pwm_pkg.sv
// Shared constants and FSM encoding for the PWM generator / capture pair.
package pwm_pkg;

    localparam int PWM_CNTR_LEN = 9;

    typedef enum logic [1:0] {
        SYNC = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } pwm_state_e;

endpackage

// File: rtl/pwm_edge_detect.sv
// Two-flop synchroniser plus history flop; yields the clean level and
// single-cycle rise/fall pulses of an asynchronous input.
module pwm_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic i_sig,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic prev_q, prev_d;

    always_comb begin
        s1_d   = i_sig;
        s2_d   = s1_q;
        prev_d = s2_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            prev_q <= prev_d;
        end
    end

    assign o_level = s2_q;
    assign o_rise  = s2_q & ~prev_q;
    assign o_fall  = ~s2_q & prev_q;

endmodule

// File: rtl/pwm_capture.sv
// PWM receiver: measures high time and rising-to-rising period in clk cycles.
// Optional stuck-input timeout enabled by defining PWM_CAPTURE_TIMEOUT_EN.
import pwm_pkg::*;

module pwm_capture #(
    parameter int CNTR_LEN = PWM_CNTR_LEN
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_pwm,
    output logic [CNTR_LEN-1:0] o_high,
    output logic [CNTR_LEN-1:0] o_period,
    output logic                o_valid,
    output logic                o_overflow,
    output logic                o_timeout,
    output logic                o_level
);

`ifdef PWM_CAPTURE_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    localparam logic [CNTR_LEN-1:0] MAX = '1;
    localparam logic [CNTR_LEN-1:0] ONE = CNTR_LEN'(1);

    logic level, rise, fall;

    pwm_edge_detect u_edge (
        .clk    (clk),
        .rst    (rst),
        .i_sig  (i_pwm),
        .o_level(level),
        .o_rise (rise),
        .o_fall (fall)
    );

    pwm_state_e          state_q, state_d;
    logic [CNTR_LEN-1:0] period_cnt_q, period_cnt_d;
    logic [CNTR_LEN-1:0] high_cnt_q, high_cnt_d;
    logic                sat_flag_q, sat_flag_d;
    logic [CNTR_LEN-1:0] high_q, high_d;
    logic [CNTR_LEN-1:0] period_q, period_d;
    logic                valid_q, valid_d;
    logic                overflow_q, overflow_d;
    logic                timeout_q, timeout_d;

    logic                period_max;
    logic [CNTR_LEN-1:0] period_inc;
    logic [CNTR_LEN-1:0] high_inc;

    assign period_max = (period_cnt_q == MAX);
    assign period_inc = period_max ? period_cnt_q : period_cnt_q + ONE;
    assign high_inc   = (high_cnt_q == MAX) ? high_cnt_q : high_cnt_q + ONE;

    always_comb begin
        state_d      = state_q;
        period_cnt_d = period_cnt_q;
        high_cnt_d   = high_cnt_q;
        sat_flag_d   = sat_flag_q;
        high_d       = high_q;
        period_d     = period_q;
        valid_d      = 1'b0;
        overflow_d   = overflow_q;
        timeout_d    = timeout_q;

        unique case (state_q)
            SYNC: begin
                if (rise) begin
                    state_d      = HIGH;
                    period_cnt_d = ONE;
                    high_cnt_d   = ONE;
                    sat_flag_d   = 1'b0;
                end
            end
            HIGH: begin
                period_cnt_d = period_inc;
                if (fall) begin
                    state_d = LOW;
                end else begin
                    high_cnt_d = high_inc;
                end
            end
            LOW: begin
                if (rise) begin
                    period_d     = period_cnt_q;
                    high_d       = high_cnt_q;
                    valid_d      = 1'b1;
                    overflow_d   = sat_flag_q;
                    timeout_d    = 1'b0;
                    sat_flag_d   = 1'b0;
                    period_cnt_d = ONE;
                    high_cnt_d   = ONE;
                    state_d      = HIGH;
                end else begin
                    period_cnt_d = period_inc;
                end
            end
            default: state_d = SYNC;
        endcase

        // A saturated period either aborts the measurement or is flagged for publish
        if (state_q != SYNC && period_max && !rise) begin
            if (TMO_EN) begin
                state_d      = SYNC;
                timeout_d    = 1'b1;
                period_cnt_d = '0;
                high_cnt_d   = '0;
                sat_flag_d   = 1'b0;
            end else begin
                sat_flag_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= SYNC;
            period_cnt_q <= '0;
            high_cnt_q   <= '0;
            sat_flag_q   <= 1'b0;
            high_q       <= '0;
            period_q     <= '0;
            valid_q      <= 1'b0;
            overflow_q   <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            period_cnt_q <= period_cnt_d;
            high_cnt_q   <= high_cnt_d;
            sat_flag_q   <= sat_flag_d;
            high_q       <= high_d;
            period_q     <= period_d;
            valid_q      <= valid_d;
            overflow_q   <= overflow_d;
            timeout_q    <= timeout_d;
        end
    end

    assign o_high     = high_q;
    assign o_period   = period_q;
    assign o_valid    = valid_q;
    assign o_overflow = overflow_q;
    assign o_timeout  = timeout_q;
    assign o_level    = level;

endmodule
